xgemac_pkt_rx_reader: RTL and testbench

Packet-side consumer of the XGEMAC receive interface, the reading end of the frame stream the MAC presents on pkt_rx_*. It waits for pkt_rx_avail, issues pkt_rx_ren with credit-based flow control, and checks sop/eop framing through a one-beat staging register. It buffers beats in an internal FIFO and replays them on a valid/ready stream toward the host-side logic.

---
 rtl/xgemac_pkt_rx_reader_pkg.sv | 28 ++
 rtl/xgemac_sync_fifo.sv | 54 +++++
 rtl/xgemac_pkt_rx_reader.sv | 170 +++++++++++++++++
 tb/tb_xgemac_pkt_rx_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgemac_pkt_rx_reader_pkg.sv
// Shared types for the XGEMAC packet-receive reader: beat record, read FSM states
// and the per-beat byte-count helper.
package xgemac_pkt_rx_reader_pkg;

   localparam int BYTES_PER_BEAT = 8;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
   } rx_beat_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_READ,
      RD_GAP
   } rd_state_t;

   // Valid bytes carried by a beat; a modulo of 0 on eop means a full beat.
   function automatic logic [3:0] beat_bytes(input rx_beat_t b);
      if (b.eop && (b.mod != 3'd0))
         return {1'b0, b.mod};
      return 4'(BYTES_PER_BEAT);
   endfunction

endpackage

// File: rtl/xgemac_sync_fifo.sv
// First-word-fall-through FIFO of rx_beat_t; the head entry is presented whenever
// the FIFO is non-empty and is zero when empty.
module xgemac_sync_fifo
   import xgemac_pkt_rx_reader_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  rx_beat_t                 wr_beat_i,
   input  logic                     rd_en_i,
   output rx_beat_t                 rd_beat_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   rx_beat_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rd_fire;

   always_comb begin
      rd_fire  = rd_en_i & (count_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
      rd_ptr_d = rd_ptr_q + AW'(rd_fire);
      count_d  = count_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_fire);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i)
         mem_q[wr_ptr_q] <= wr_beat_i;
   end

   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_beat_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/xgemac_pkt_rx_reader.sv
// Reads frames from the XGEMAC pkt_rx interface with credit flow control, repairs
// framing through a one-beat stage, and replays beats on a valid/ready stream.
// Optional statistics outputs: define XGEMAC_RX_READER_STATS_EN.
module xgemac_pkt_rx_reader
   import xgemac_pkt_rx_reader_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = 64,
   parameter int MOD_W      = 3,
   parameter int CNT_W      = 32
) (
   input  logic              clk_156m25,
   input  logic              reset_156m25,
   input  logic              pkt_rx_avail,
   output logic              pkt_rx_ren,
   input  logic              pkt_rx_val,
   input  logic [DATA_W-1:0] pkt_rx_data,
   input  logic              pkt_rx_sop,
   input  logic              pkt_rx_eop,
   input  logic [MOD_W-1:0]  pkt_rx_mod,
   input  logic              pkt_rx_err,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_sop,
   output logic              m_eop,
   output logic [MOD_W-1:0]  m_mod,
   output logic              m_err,
   output logic              busy
`ifdef XGEMAC_RX_READER_STATS_EN
   ,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  proto_err_cnt,
   output logic [CNT_W-1:0]  byte_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);

   rd_state_t     state_q, state_d;
   logic          ren_q;
   logic          stg_v_q, stg_v_d;
   logic          first_q, first_d;
   rx_beat_t      stg_q;
   rx_beat_t      in_beat, fifo_wr_beat, fifo_rd_beat;
   logic [AW:0]   fifo_cnt;
   logic [AW+1:0] occ;
   logic          fifo_empty, fifo_we;
   logic          in_read, acc, credit, miss_sop, force_eop;

   always_comb begin
      in_read    = (state_q == RD_READ);
      acc        = pkt_rx_val & in_read;
      // Occupancy includes the staged beat and the beat already requested from the MAC.
      occ        = (AW+2)'(fifo_cnt) + (AW+2)'(stg_v_q) + (AW+2)'(ren_q);
      credit     = (occ < (AW+2)'(FIFO_DEPTH));
      pkt_rx_ren = in_read & credit & ~(pkt_rx_val & pkt_rx_eop);
      miss_sop   = acc & first_q & ~pkt_rx_sop;
      force_eop  = acc & pkt_rx_sop & stg_v_q & ~stg_q.eop;
      fifo_we    = stg_v_q & (stg_q.eop | acc);

      in_beat.data = pkt_rx_data;
      in_beat.sop  = pkt_rx_sop | first_q;
      in_beat.eop  = pkt_rx_eop;
      in_beat.mod  = pkt_rx_eop ? pkt_rx_mod : '0;
      in_beat.err  = (pkt_rx_err & pkt_rx_eop) | (first_q & ~pkt_rx_sop);

      fifo_wr_beat = stg_q;
      if (force_eop) begin
         fifo_wr_beat.eop = 1'b1;
         fifo_wr_beat.err = 1'b1;
         fifo_wr_beat.mod = '0;
      end

      stg_v_d = stg_v_q;
      if (acc)
         stg_v_d = 1'b1;
      else if (fifo_we)
         stg_v_d = 1'b0;

      first_d = in_read ? (first_q & ~acc) : 1'b1;

      state_d = state_q;
      case (state_q)
         RD_IDLE: if (pkt_rx_avail && credit) state_d = RD_READ;
         RD_READ: if (acc && pkt_rx_eop)      state_d = RD_GAP;
         RD_GAP:                              state_d = RD_IDLE;
         default:                             state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         state_q <= RD_IDLE;
         ren_q   <= 1'b0;
         stg_v_q <= 1'b0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ren_q   <= pkt_rx_ren;
         stg_v_q <= stg_v_d;
         first_q <= first_d;
      end
   end

   always_ff @(posedge clk_156m25) begin
      if (acc)
         stg_q <= in_beat;
   end

   xgemac_sync_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_156m25),
      .rst_i     (reset_156m25),
      .wr_en_i   (fifo_we),
      .wr_beat_i (fifo_wr_beat),
      .rd_en_i   (m_ready),
      .rd_beat_o (fifo_rd_beat),
      .empty_o   (fifo_empty),
      .count_o   (fifo_cnt)
   );

   assign m_valid = ~fifo_empty;
   assign m_data  = fifo_rd_beat.data;
   assign m_sop   = fifo_rd_beat.sop;
   assign m_eop   = fifo_rd_beat.eop;
   assign m_mod   = fifo_rd_beat.mod;
   assign m_err   = fifo_rd_beat.err;
   assign busy    = (state_q != RD_IDLE) | stg_v_q | ~fifo_empty;

`ifdef XGEMAC_RX_READER_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, err_cnt_q, proto_cnt_q, byte_cnt_q;
   logic             proto_ev;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign proto_ev = force_eop | miss_sop | (pkt_rx_val & ~in_read);

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         proto_cnt_q <= '0;
         byte_cnt_q  <= '0;
      end else begin
         if (fifo_we && fifo_wr_beat.eop)
            frame_cnt_q <= sat_add(frame_cnt_q, 4'd1);
         if (fifo_we && fifo_wr_beat.eop && fifo_wr_beat.err)
            err_cnt_q <= sat_add(err_cnt_q, 4'd1);
         if (proto_ev)
            proto_cnt_q <= sat_add(proto_cnt_q, 4'd1);
         if (fifo_we)
            byte_cnt_q <= sat_add(byte_cnt_q, beat_bytes(fifo_wr_beat));
      end
   end

   assign frame_cnt     = frame_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign proto_err_cnt = proto_cnt_q;
   assign byte_cnt      = byte_cnt_q;
`endif

endmodule

// File: tb/tb_xgemac_pkt_rx_reader.sv
// Randomized bench for xgemac_pkt_rx_reader: a MAC model feeds frames, and a
// frame-level expected beat list plus statistics totals are checked at the output.
module tb_xgemac_pkt_rx_reader;
   import xgemac_pkt_rx_reader_pkg::*;

   logic        clk_156m25 = 1'b0;
   logic        reset_156m25 = 1'b1;
   logic        pkt_rx_avail = 1'b0;
   logic        pkt_rx_ren;
   logic        pkt_rx_val = 1'b0;
   logic [63:0] pkt_rx_data = '0;
   logic        pkt_rx_sop = 1'b0;
   logic        pkt_rx_eop = 1'b0;
   logic [2:0]  pkt_rx_mod = '0;
   logic        pkt_rx_err = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [63:0] m_data;
   logic        m_sop, m_eop, m_err, busy;
   logic [2:0]  m_mod;
`ifdef XGEMAC_RX_READER_STATS_EN
   logic [31:0] frame_cnt, err_cnt, proto_err_cnt, byte_cnt;
`endif

   always #5 clk_156m25 = ~clk_156m25;

   xgemac_pkt_rx_reader #(.FIFO_DEPTH(16), .DATA_W(64), .MOD_W(3), .CNT_W(32)) dut (
      .clk_156m25    (clk_156m25),
      .reset_156m25  (reset_156m25),
      .pkt_rx_avail  (pkt_rx_avail),
      .pkt_rx_ren    (pkt_rx_ren),
      .pkt_rx_val    (pkt_rx_val),
      .pkt_rx_data   (pkt_rx_data),
      .pkt_rx_sop    (pkt_rx_sop),
      .pkt_rx_eop    (pkt_rx_eop),
      .pkt_rx_mod    (pkt_rx_mod),
      .pkt_rx_err    (pkt_rx_err),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_sop         (m_sop),
      .m_eop         (m_eop),
      .m_mod         (m_mod),
      .m_err         (m_err),
      .busy          (busy)
`ifdef XGEMAC_RX_READER_STATS_EN
      ,
      .frame_cnt     (frame_cnt),
      .err_cnt       (err_cnt),
      .proto_err_cnt (proto_err_cnt),
      .byte_cnt      (byte_cnt)
`endif
   );

   rx_beat_t mac_q[$];
   rx_beat_t exp_q[$];
   int total = 0, bad = 0, cyc = 0;
   int exp_frames = 0, exp_errs = 0, exp_proto = 0, exp_bytes = 0;
   int rdy_prob = 100;
   bit inj = 0, rst_next = 0;
   int ren_cnt = 0, vin_cnt = 0, first_in = -1, first_out = -1;
   int gap_cnt = 0, last_gap = -1;
   bit gap_on = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Builds one MAC frame and the beats the reader must deliver for it.
   task automatic add_frame(input int nb, input bit sop_ok, input bit has_eop,
                            input logic [2:0] mod, input bit err);
      rx_beat_t b, e;
      for (int i = 0; i < nb; i++) begin
         b.data = {$urandom, $urandom};
         b.sop  = (i == 0) && sop_ok;
         b.eop  = (i == nb - 1) && has_eop;
         b.mod  = b.eop ? mod : 3'd0;
         b.err  = b.eop ? err : 1'b0;
         mac_q.push_back(b);
         e = b;
         if (i == 0 && !sop_ok) begin
            e.sop = 1'b1; e.err = 1'b1; exp_proto++;
         end
         if (i == nb - 1 && !has_eop) begin
            e.eop = 1'b1; e.err = 1'b1; e.mod = 3'd0; exp_proto++;
         end
         exp_q.push_back(e);
         if (e.eop) begin
            exp_frames++;
            if (e.err) exp_errs++;
            exp_bytes += (e.mod == 3'd0) ? 8 : int'(e.mod);
         end else begin
            exp_bytes += 8;
         end
      end
   endtask

   task automatic step();
      bit ren_s;
      rx_beat_t ob, e, mb;
      @(negedge clk_156m25);
      cyc++;
      ren_s = pkt_rx_ren && !reset_156m25;
      if (!reset_156m25) begin
         if (pkt_rx_ren) ren_cnt++;
         if (pkt_rx_val) begin
            vin_cnt++;
            if (first_in < 0) first_in = cyc;
         end
         if (pkt_rx_val && pkt_rx_eop) begin
            chk("ren_at_eop", 128'(pkt_rx_ren), 128'(0));
            gap_on = 1; gap_cnt = 0;
         end
         if (gap_on) begin
            if (!pkt_rx_ren) gap_cnt++;
            else begin gap_on = 0; last_gap = gap_cnt; end
         end
         if (m_valid && first_out < 0) first_out = cyc;
         if (m_valid && m_ready) begin
            ob.data = m_data; ob.sop = m_sop; ob.eop = m_eop; ob.mod = m_mod; ob.err = m_err;
            if (exp_q.size() == 0) chk("extra_beat", 128'(ob), 128'(0));
            else begin
               e = exp_q.pop_front();
               chk("beat", 128'(ob), 128'(e));
            end
         end
      end
      @(posedge clk_156m25);
      #1;
      reset_156m25 = rst_next;
      pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
      pkt_rx_mod = '0; pkt_rx_err = 1'b0; pkt_rx_data = '0;
      if (rst_next) begin
         mac_q.delete(); exp_q.delete();
         exp_frames = 0; exp_errs = 0; exp_proto = 0; exp_bytes = 0;
         gap_on = 0;
      end else if (inj) begin
         pkt_rx_val = 1'b1; pkt_rx_sop = 1'b1; pkt_rx_data = {$urandom, $urandom};
         inj = 0;
      end else if (ren_s && mac_q.size() > 0) begin
         mb = mac_q.pop_front();
         pkt_rx_val = 1'b1; pkt_rx_data = mb.data; pkt_rx_sop = mb.sop;
         pkt_rx_eop = mb.eop; pkt_rx_mod = mb.mod; pkt_rx_err = mb.err;
      end
      pkt_rx_avail = !rst_next && (mac_q.size() > 0);
      m_ready = ($urandom_range(0, 99) < rdy_prob);
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((exp_q.size() > 0 || mac_q.size() > 0 || busy) && n < maxc) begin
         step(); n++;
      end
      if (n >= maxc) chk("drain_timeout", 128'(1), 128'(0));
      repeat (3) step();
   endtask

   task automatic stats_chk(input string tag);
`ifdef XGEMAC_RX_READER_STATS_EN
      chk({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_frames));
      chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(exp_errs));
      chk({tag, "_proto_cnt"}, 128'(proto_err_cnt), 128'(exp_proto));
      chk({tag, "_byte_cnt"}, 128'(byte_cnt), 128'(exp_bytes));
`else
      chk({tag, "_idle"}, 128'(busy), 128'(0));
`endif
   endtask

   initial begin
      int n, len, kind;
      rst_next = 1;
      repeat (3) step();
      rst_next = 0;
      step();
      chk("reset_state", 128'({pkt_rx_ren, m_valid, m_data, m_sop, m_eop, m_mod, m_err, busy}), 128'(0));
      stats_chk("reset");

      // 64-byte frame with a always-ready sink
      rdy_prob = 100; m_ready = 1'b1;
      ren_cnt = 0; first_in = -1; first_out = -1;
      add_frame(8, 1, 1, 3'd0, 0);
      drain(300);
      chk("t1_ren_cycles", 128'(ren_cnt), 128'(8));
      chk("t1_latency", 128'(first_out - first_in), 128'(2));
      stats_chk("t1");

      // Long frame against a stalled sink, then release
      rdy_prob = 0; m_ready = 1'b0; ren_cnt = 0;
      add_frame(20, 1, 1, 3'd5, 0);
      repeat (80) step();
      chk("t2_ren_stall", 128'(ren_cnt), 128'(16));
      chk("t2_hold_valid", 128'(m_valid), 128'(1));
      rdy_prob = 100;
      drain(400);
      stats_chk("t2");

      // Frame A cut short by the sop of frame B
      add_frame(3, 1, 0, 3'd0, 0);
      add_frame(4, 1, 1, 3'd3, 0);
      drain(300);
      stats_chk("t3");

      // 65-byte frame flagged bad by the MAC
      add_frame(9, 1, 1, 3'd1, 1);
      drain(300);
      stats_chk("t4");

      // Back-to-back frames
      gap_on = 0; last_gap = -1;
      add_frame(4, 1, 1, 3'd0, 0);
      add_frame(5, 1, 1, 3'd2, 0);
      drain(300);
      chk("t5_gap", 128'(last_gap), 128'(3));
      stats_chk("t5");

      // Unrequested beat while idle
      inj = 1;
      step();
      exp_proto++;
      drain(50);
      chk("t6_no_out", 128'(m_valid), 128'(0));
      stats_chk("t6");

      // Reset in the middle of a frame
      rdy_prob = 100; vin_cnt = 0; n = 0;
      add_frame(10, 1, 1, 3'd0, 0);
      while (vin_cnt < 4 && n < 100) begin step(); n++; end
      if (n >= 100) chk("t7_beat_timeout", 128'(1), 128'(0));
      rst_next = 1;
      step();
      rst_next = 0;
      step();
      chk("t7_reset_out", 128'({pkt_rx_ren, m_valid, m_data, m_sop, m_eop, m_mod, m_err, busy}), 128'(0));
      stats_chk("t7_reset");
      add_frame(6, 1, 1, 3'd4, 0);
      drain(300);
      stats_chk("t7_after");

      // Random mix with a throttled sink
      for (int f = 0; f < 15; f++) begin
         len  = $urandom_range(1, 20);
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            add_frame($urandom_range(1, 6), 1, 0, 3'd0, 0);
            add_frame(len, 1, 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end else if (kind == 1) begin
            add_frame(len, 0, 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end else begin
            add_frame(len, 1, 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end
      end
      rdy_prob = $urandom_range(30, 90);
      drain(8000);
      chk("rand_leftover", 128'(exp_q.size()), 128'(0));
      stats_chk("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
